// File: rtl/display_pkg.sv
// Shared display geometry, console control codes and console FSM state type.
package display_pkg;

  localparam int ASCII_SIZE = 8;
  localparam int CHARS_HORZ = 40;   // 640 px / 16 px glyph
  localparam int CHARS_VERT = 30;   // 480 px / 16 px glyph

  localparam int ROW_W = $clog2(CHARS_VERT);
  localparam int COL_W = $clog2(CHARS_HORZ);

  localparam logic [ASCII_SIZE-1:0] ASCII_LF    = 8'h0A;
  localparam logic [ASCII_SIZE-1:0] ASCII_CR    = 8'h0D;
  localparam logic [ASCII_SIZE-1:0] ASCII_BS    = 8'h08;
  localparam logic [ASCII_SIZE-1:0] ASCII_FF    = 8'h0C;
  localparam logic [ASCII_SIZE-1:0] ASCII_SPACE = 8'h20;
  localparam logic [ASCII_SIZE-1:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } console_state_t;

  // Printable range is space through tilde inclusive.
  function automatic logic is_printable(input logic [ASCII_SIZE-1:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte handshake between the processor console port and the text console.
interface text_console_if;
  import display_pkg::*;

  logic                  char_valid;
  logic [ASCII_SIZE-1:0] char_data;
  logic                  char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/text_console.sv
// Character-stream front end: cursor tracking, control codes, line wrap,
// multi-cycle scroll and clear of the registered character cell array.
module text_console
  import display_pkg::*;
(
  input  logic                  clk,
  input  logic                  RESET,
  text_console_if.slave         con,
  output logic [ASCII_SIZE-1:0] DisplayBuffer [CHARS_VERT][CHARS_HORZ],
  output logic [ROW_W-1:0]      cursor_row,
  output logic [COL_W-1:0]      cursor_col,
  output logic                  busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHARS_VERT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_HORZ - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  logic [ASCII_SIZE-1:0] cells_q [CHARS_VERT][CHARS_HORZ];
  console_state_t        state_q;
  logic [ROW_W-1:0]      row_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      idx_q;
  logic                  ready_q;
  logic                  busy_q;

  logic accept;
  logic printable;
  logic wrap;

  // Decode the accepted byte; wrap covers both LF and a print in the last column.
  always_comb begin
    accept    = con.char_valid && ready_q && (state_q == IDLE);
    printable = is_printable(con.char_data);
    wrap      = accept && ((printable && (col_q == LAST_COL)) ||
                           (con.char_data == ASCII_LF));
  end

  // Console FSM with cursor, cell array and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int r = 0; r < CHARS_VERT; r++)
        for (int c = 0; c < CHARS_HORZ; c++)
          cells_q[r][c] <= ASCII_SPACE;
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              cells_q[row_q][col_q] <= con.char_data;
              // Last column resets to 0; the row step comes from wrap below.
              col_q <= (col_q < LAST_COL) ? col_q + COL_ONE : '0;
            end else if (con.char_data == ASCII_LF || con.char_data == ASCII_CR) begin
              col_q <= '0;
            end else if (con.char_data == ASCII_BS) begin
              // No reverse wrap onto the previous row.
              if (col_q != '0) begin
                col_q                          <= col_q - COL_ONE;
                cells_q[row_q][col_q - COL_ONE] <= ASCII_SPACE;
              end
            end else if (con.char_data == ASCII_FF) begin
              state_q <= CLEAR;
              idx_q   <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
            // Wrapping off the bottom row starts a scroll; the byte just
            // written sits in that row and moves up with it.
            if (wrap) begin
              if (row_q < LAST_ROW) begin
                row_q <= row_q + ROW_ONE;
              end else begin
                state_q <= SCROLL;
                idx_q   <= '0;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end
          end
        end

        SCROLL: begin
          if (idx_q == LAST_ROW) begin
            for (int c = 0; c < CHARS_HORZ; c++)
              cells_q[LAST_ROW][c] <= ASCII_SPACE;
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            for (int c = 0; c < CHARS_HORZ; c++)
              cells_q[idx_q][c] <= cells_q[idx_q + ROW_ONE][c];
            idx_q <= idx_q + ROW_ONE;
          end
        end

        CLEAR: begin
          for (int c = 0; c < CHARS_HORZ; c++)
            cells_q[idx_q][c] <= ASCII_SPACE;
          if (idx_q == LAST_ROW) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + ROW_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DisplayBuffer  = cells_q;
  assign con.char_ready = ready_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_text_console.sv
// Directed, table-driven bench for text_console.
module tb_text_console;
  import display_pkg::*;

  localparam int WAIT_LIMIT = 200;

  logic                  clk;
  logic                  RESET;
  logic [ASCII_SIZE-1:0] db [CHARS_VERT][CHARS_HORZ];
  logic [ROW_W-1:0]      cursor_row;
  logic [COL_W-1:0]      cursor_col;
  logic                  busy;

  text_console_if tif ();

  text_console dut (
    .clk          (clk),
    .RESET        (RESET),
    .con          (tif),
    .DisplayBuffer(db),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_row;
    int         exp_col;
    int         cr;
    int         cc;
    logic [7:0] exp_cell;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Count cells differing from v across the whole buffer.
  function automatic int cnt_ne(input logic [7:0] v);
    int n = 0;
    for (int r = 0; r < CHARS_VERT; r++)
      for (int c = 0; c < CHARS_HORZ; c++)
        if (db[r][c] !== v) n++;
    return n;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
  endtask

  // Offer one byte, hold until accepted; waits = cycles spent with ready low.
  task automatic send(input logic [7:0] d, output int waits);
    tif.char_valid = 1'b1;
    tif.char_data  = d;
    waits = 0;
    while (!tif.char_ready && waits < WAIT_LIMIT) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= WAIT_LIMIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted in %0d cycles", d, waits);
    end
    @(posedge clk); #1;
    tif.char_valid = 1'b0;
  endtask

  // Cycles until sig-low condition ends, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!tif.char_ready && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int bad;

    // After 41 'X' from reset the cursor is (1,1) with cell[1][0]='X'.
    tbl[0]  = '{8'h08, 1, 0, 1, 0, 8'h20};  // BS erases the X
    tbl[1]  = '{8'h08, 1, 0, 1, 0, 8'h20};  // BS at col 0: nothing
    tbl[2]  = '{8'h51, 1, 1, 1, 0, 8'h51};  // 'Q'
    tbl[3]  = '{8'h0D, 1, 0, 1, 0, 8'h51};  // CR keeps row
    tbl[4]  = '{8'h07, 1, 0, 1, 0, 8'h51};  // BEL discarded
    tbl[5]  = '{8'h5A, 1, 1, 1, 0, 8'h5A};  // 'Z' overwrites
    tbl[6]  = '{8'h0A, 2, 0, 1, 0, 8'h5A};  // LF
    tbl[7]  = '{8'h7E, 2, 1, 2, 0, 8'h7E};  // top of printable range
    tbl[8]  = '{8'h7F, 2, 1, 2, 1, 8'h20};  // DEL discarded
    tbl[9]  = '{8'h1F, 2, 1, 2, 1, 8'h20};  // below space discarded
    tbl[10] = '{8'h08, 2, 0, 2, 0, 8'h20};  // BS erases '~'

    tif.char_valid = 1'b0;
    tif.char_data  = '0;
    RESET          = 1'b0;

    // Reset state
    do_reset();
    chk("rst_cells", cnt_ne(8'h20), 0);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_ready", int'(tif.char_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // Back-to-back printable bytes, one per cycle
    tif.char_valid = 1'b1;
    tif.char_data  = 8'h41;
    @(posedge clk); #1;
    chk("ab_ready_held", int'(tif.char_ready), 1);
    chk("ab_col_after_a", int'(cursor_col), 1);
    tif.char_data = 8'h42;
    @(posedge clk); #1;
    tif.char_valid = 1'b0;
    chk("ab_cell00", int'(db[0][0]), 8'h41);
    chk("ab_cell01", int'(db[0][1]), 8'h42);
    chk("ab_row", int'(cursor_row), 0);
    chk("ab_col", int'(cursor_col), 2);

    // Line wrap, then control-code table
    do_reset();
    repeat (41) send(8'h58, w);
    bad = 0;
    for (int c = 0; c < CHARS_HORZ; c++) if (db[0][c] !== 8'h58) bad++;
    chk("wrap_row0", bad, 0);
    chk("wrap_cell10", int'(db[1][0]), 8'h58);
    chk("wrap_row", int'(cursor_row), 1);
    chk("wrap_col", int'(cursor_col), 1);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].data, w);
      chk($sformatf("tbl%0d_row", i), int'(cursor_row), tbl[i].exp_row);
      chk($sformatf("tbl%0d_col", i), int'(cursor_col), tbl[i].exp_col);
      chk($sformatf("tbl%0d_cell", i), int'(db[tbl[i].cr][tbl[i].cc]), int'(tbl[i].exp_cell));
    end

    // Scroll: row r holds '0'+(r%10); last row 39 cells then LF
    do_reset();
    for (int r = 0; r < CHARS_VERT - 1; r++)
      for (int c = 0; c < CHARS_HORZ; c++)
        send(8'(8'h30 + r % 10), w);
    for (int c = 0; c < CHARS_HORZ - 1; c++) send(8'h39, w);
    chk("pre_scroll_row", int'(cursor_row), 29);
    chk("pre_scroll_col", int'(cursor_col), 39);
    send(ASCII_LF, w);
    chk("scroll_busy", int'(busy), 1);
    count_not_ready(n);
    chk("scroll_ready_low_cycles", n, 30);
    bad = 0;
    for (int r = 0; r < CHARS_VERT - 2; r++)
      for (int c = 0; c < CHARS_HORZ; c++)
        if (db[r][c] !== 8'(8'h30 + (r + 1) % 10)) bad++;
    chk("scroll_rows_shifted", bad, 0);
    chk("scroll_row28_c0", int'(db[28][0]), 8'h39);
    chk("scroll_row28_c39", int'(db[28][39]), 8'h20);
    bad = 0;
    for (int c = 0; c < CHARS_HORZ; c++) if (db[29][c] !== 8'h20) bad++;
    chk("scroll_row29_blank", bad, 0);
    chk("scroll_cur_row", int'(cursor_row), 29);
    chk("scroll_cur_col", int'(cursor_col), 0);
    chk("scroll_busy_done", int'(busy), 0);

    // Backpressure: byte held through a scroll lands once at (29,0)
    repeat (CHARS_HORZ - 1) send(8'h62, w);
    send(ASCII_LF, w);
    send(8'h41, w);
    chk("bp_wait_cycles", w, 30);
    chk("bp_cell29_0", int'(db[29][0]), 8'h41);
    chk("bp_cell29_1", int'(db[29][1]), 8'h20);
    chk("bp_cell28_0", int'(db[28][0]), 8'h62);
    chk("bp_cell28_39", int'(db[28][39]), 8'h20);
    chk("bp_row", int'(cursor_row), 29);
    chk("bp_col", int'(cursor_col), 1);

    // Clear
    send(ASCII_FF, w);
    chk("clr_ready_low", int'(tif.char_ready), 0);
    count_busy(n);
    chk("clr_busy_cycles", n, 30);
    chk("clr_cells", cnt_ne(8'h20), 0);
    chk("clr_row", int'(cursor_row), 0);
    chk("clr_col", int'(cursor_col), 0);
    chk("clr_ready", int'(tif.char_ready), 1);

    // Clear aborted by reset on its 10th busy cycle
    repeat (20) send(ASCII_LF, w);
    send(8'h4B, w);
    send(8'h4C, w);
    chk("cr_pre_row", int'(cursor_row), 20);
    chk("cr_pre_col", int'(cursor_col), 2);
    send(ASCII_FF, w);
    repeat (9) begin @(posedge clk); #1; end
    chk("cr_busy_10th", int'(busy), 1);
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    chk("cr_cell20_0", int'(db[20][0]), 8'h20);
    chk("cr_cells", cnt_ne(8'h20), 0);
    chk("cr_row", int'(cursor_row), 0);
    chk("cr_col", int'(cursor_col), 0);
    chk("cr_busy", int'(busy), 0);
    chk("cr_ready", int'(tif.char_ready), 1);
    send(8'h4D, w);
    chk("cr_idle_wait", w, 0);
    chk("cr_idle_cell", int'(db[0][0]), 8'h4D);
    chk("cr_idle_col", int'(cursor_col), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Character-stream front end for the VGA text path.
- Accepts one ASCII byte per handshake from the processor's memory-mapped console port.
- Maintains the CHARS_VERT x CHARS_HORZ display buffer that the draw block consumes as charBuffer.
- Handles cursor advance, line wrap, control characters, multi-cycle scrolling and screen clear.

Parameters:
- ASCII_SIZE, 8: bits per character cell.
- CHARS_HORZ, 40: columns (640 px / 16 px glyph).
- CHARS_VERT, 30: rows (480 px / 16 px glyph).

Ports:
- clk  input  1  single system clock, the same clock that drives the processor and draw blocks.
- RESET  input  1  synchronous, active-high reset.
- char_valid  input  1  the char_data byte is offered this cycle.
- char_data  input  ASCII_SIZE  character or control code.
- char_ready  output  1  block accepts a byte this cycle. A transfer occurs when char_valid && char_ready.
- DisplayBuffer  output  [ASCII_SIZE-1:0] x [CHARS_VERT-1:0][CHARS_HORZ-1:0]  registered cell array, unpacked array port feeding draw.charBuffer.
- cursor_row  output  $clog2(CHARS_VERT)  current row.
- cursor_col  output  $clog2(CHARS_HORZ)  current column.
- busy  output  1  a SCROLL or CLEAR operation is in progress.

Behaviour:
Reset (RESET sampled high at a clk edge):
- All cells become 0x20; cursor_row = 0, cursor_col = 0.
- State becomes IDLE; busy = 0; char_ready = 1 from the following cycle.
- RESET asserted mid-SCROLL or mid-CLEAR aborts the operation and applies the same values.

States:
- IDLE: char_ready = 1, busy = 0.
- SCROLL: char_ready = 0, busy = 1.
- CLEAR: char_ready = 0, busy = 1.

Accepted byte in IDLE. All effects are visible at the next edge; a cell write and the cursor update happen in the same cycle.
- Printable 0x20-0x7E:
  - Write to cell [row][col].
  - If col < CHARS_HORZ-1: col+1.
  - Else col = 0 and the line wraps (see below).
- 0x0A LF: col = 0, then line wrap.
- 0x0D CR: col = 0, row unchanged.
- 0x08 BS:
  - If col > 0: col-1 and write 0x20 at the new col.
  - At col 0: no effect (no reverse row wrap).
- 0x0C FF: enter CLEAR.
- Any other code: accepted and discarded, with no buffer or cursor change.

Line wrap:
- If row < CHARS_VERT-1: row+1.
- Else row stays CHARS_VERT-1 and the block enters SCROLL.
- The printable character is written to its cell before the scroll starts, so it moves up with its row.

SCROLL:
- Internal index idx starts at 0.
- Each cycle: row[idx] <= row[idx+1], idx+1.
- When idx = CHARS_VERT-2, the shift completes that cycle; the next cycle writes 0x20 to every cell of row CHARS_VERT-1 and returns to IDLE.
- Total CHARS_VERT cycles with char_ready = 0. The cursor stays at (CHARS_VERT-1, 0).

CLEAR:
- Each cycle writes 0x20 to row[idx], for idx 0..CHARS_VERT-1.
- Then returns to IDLE with the cursor at (0,0).
- Total CHARS_VERT cycles.

Other rules:
- Cursor counters never exceed CHARS_HORZ-1 / CHARS_VERT-1.
- No index arithmetic may wrap modulo 2^n.
- char_valid while char_ready = 0 has no effect; the producer must hold char_valid and char_data until accepted.
- DisplayBuffer is always the registered array. The draw block may sample it at any time and will see intermediate rows during SCROLL or CLEAR; this tearing is acceptable.

Decomposition:
- Package display_pkg holds:
  - ASCII_SIZE, CHARS_HORZ, CHARS_VERT, shared with Processor and draw.
  - Control-code constants: ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF, ASCII_SPACE.
  - Typedef console_state_t {IDLE, SCROLL, CLEAR}.
- Single module; no sub-module. The FSM, cursor counters and cell array belong together.

Test Plan:
- Reset: hold RESET 2 cycles -> every cell 0x20, cursor (0,0), char_ready = 1, busy = 0.
- Printable: send "A" (0x41), "B" (0x42) back-to-back -> cell[0][0] = 0x41, cell[0][1] = 0x42, cursor (0,2), one byte accepted per cycle.
- Wrap and control codes:
  - 41 bytes of 0x58 -> row 0 is all 0x58, cell[1][0] = 0x58, cursor (1,1).
  - Then BS -> cell[1][0] = 0x20, cursor (1,0).
  - Then BS again -> no change.
  - Then CR -> cursor (1,0).
  - Then 0x07 -> no change.
- Scroll:
  - Fill rows so that row r holds 0x30+(r%10), then issue LF on row 29.
  - Expect char_ready low for exactly 30 cycles.
  - Afterwards row r holds the former row r+1, row 29 is all 0x20, cursor (29,0).
- Clear/reset interaction:
  - FF -> busy for 30 cycles, then all cells 0x20, cursor (0,0).
  - Repeat the FF with RESET asserted on the 10th busy cycle -> reset values the next cycle, state IDLE.
- Backpressure: hold char_valid with 0x41 during a SCROLL -> exactly one write of 0x41 at (29,0), in the first IDLE cycle after the scroll.
